// File: rtl/alu_seq16.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq16
//  Purpose  : 16-bit PASS/ADD/SUB sequencer built on an external 8-bit ALU.
//             The low byte is processed first, then the high byte; ADD/SUB
//             take one extra FIX cycle to fold the low-byte carry/borrow
//             into the high byte.
//  Revision : 1.0  initial release
// ============================================================================
module alu_seq16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        zero,
    output logic        carry,
    output logic        sign,
    output logic        overflow,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_op,
    input  logic [7:0]  alu_result,
    input  logic        alu_carry
);

    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LO   = 3'd1,
        S_HI   = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d, b_q, b_d;
    logic [2:0]  op_q, op_d;
    logic [7:0]  res_lo_q, res_lo_d, tmp_hi_q, tmp_hi_d, res_hi_q, res_hi_d;
    logic        c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;
    logic [15:0] result_q, result_d;
    logic        zero_q, zero_d, carry_q, carry_d, sign_q, sign_d;
    logic        overflow_q, overflow_d, done_q, done_d, busy_q, busy_d;
    logic [7:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [2:0]  alu_op_q, alu_op_d;

    logic        is_arith;
    logic [7:0]  final_hi;
    logic [15:0] final_res;

    assign is_arith  = (op_q == OP_ADD) || (op_q == OP_SUB);
    assign final_hi  = is_arith ? res_hi_q : tmp_hi_q;
    assign final_res = {final_hi, res_lo_q};

    // Next-state, datapath capture and ALU drive values for the following cycle
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        res_lo_d   = res_lo_q;
        tmp_hi_d   = tmp_hi_q;
        res_hi_d   = res_hi_q;
        c1_d       = c1_q;
        c2_d       = c2_q;
        c3_d       = c3_q;
        result_d   = result_q;
        zero_d     = zero_q;
        carry_d    = carry_q;
        sign_d     = sign_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                res_lo_d = alu_result;
                c1_d     = alu_carry;
                state_d  = S_HI;
            end
            S_HI: begin
                tmp_hi_d = alu_result;
                c2_d     = alu_carry;
                state_d  = is_arith ? S_FIX : S_DONE;
            end
            S_FIX: begin
                res_hi_d = alu_result;
                c3_d     = alu_carry;
                state_d  = S_DONE;
            end
            S_DONE: begin
                result_d = final_res;
                zero_d   = (final_res == 16'd0);
                sign_d   = final_res[15];
                carry_d  = is_arith & (c2_q | c3_q);
                if (op_q == OP_ADD)
                    overflow_d = (a_q[15] == b_q[15]) && (final_res[15] != a_q[15]);
                else if (op_q == OP_SUB)
                    overflow_d = (a_q[15] != b_q[15]) && (final_res[15] != a_q[15]);
                else
                    overflow_d = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered
        busy_d   = (state_d != S_IDLE);
        alu_a_d  = 8'd0;
        alu_b_d  = 8'd0;
        alu_op_d = 3'd0;
        case (state_d)
            S_LO: begin
                alu_a_d  = a_d[7:0];
                alu_b_d  = b_d[7:0];
                alu_op_d = op_d;
            end
            S_HI: begin
                alu_a_d  = a_d[15:8];
                alu_b_d  = b_d[15:8];
                alu_op_d = op_d;
            end
            S_FIX: begin
                alu_a_d  = tmp_hi_d;
                alu_b_d  = {7'd0, c1_d};
                alu_op_d = op_d;
            end
            default: begin
                alu_a_d  = 8'd0;
                alu_b_d  = 8'd0;
                alu_op_d = 3'd0;
            end
        endcase
    end

    // All state and registered outputs; asynchronous reset aborts any operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            a_q        <= 16'd0;
            b_q        <= 16'd0;
            op_q       <= 3'd0;
            res_lo_q   <= 8'd0;
            tmp_hi_q   <= 8'd0;
            res_hi_q   <= 8'd0;
            c1_q       <= 1'b0;
            c2_q       <= 1'b0;
            c3_q       <= 1'b0;
            result_q   <= 16'd0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            sign_q     <= 1'b0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            alu_a_q    <= 8'd0;
            alu_b_q    <= 8'd0;
            alu_op_q   <= 3'd0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            res_lo_q   <= res_lo_d;
            tmp_hi_q   <= tmp_hi_d;
            res_hi_q   <= res_hi_d;
            c1_q       <= c1_d;
            c2_q       <= c2_d;
            c3_q       <= c3_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            carry_q    <= carry_d;
            sign_q     <= sign_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign zero     = zero_q;
    assign carry    = carry_q;
    assign sign     = sign_q;
    assign overflow = overflow_q;
    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_op   = alu_op_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq16.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq16
//  Purpose  : Self-checking bench for alu_seq16 with an 8-bit ALU model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_seq16;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [15:0] a, b;
    logic        busy, done, zero, carry, sign, overflow;
    logic [15:0] result;
    logic [7:0]  alu_a, alu_b, alu_result;
    logic [2:0]  alu_op;
    logic        alu_carry;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0] r;
        logic        z;
        logic        c;
        logic        s;
        logic        v;
        logic [3:0]  lat;
    } exp_t;

    exp_t sb[$];

    alu_seq16 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .zero       (zero),
        .carry      (carry),
        .sign       (sign),
        .overflow   (overflow),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_carry  (alu_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit ALU: 1=ADD (carry out), 2=SUB (borrow), anything else passes alu_b
    always_comb begin
        alu_result = alu_b;
        alu_carry  = 1'b0;
        case (alu_op)
            3'd1: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            3'd2: begin
                alu_result = alu_a - alu_b;
                alu_carry  = (alu_a < alu_b);
            end
            default: begin
                alu_result = alu_b;
                alu_carry  = 1'b0;
            end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Push the 16-bit reference result, then run one operation and compare at done
    task automatic run_op(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                          input bit interfere);
        exp_t        e;
        exp_t        g;
        logic [16:0] s;
        int          dones;
        int          lat;
        e = '0;
        if (o == 3'd1) begin
            s   = {1'b0, x} + {1'b0, y};
            e.r = s[15:0];
            e.c = s[16];
            e.v = (x[15] == y[15]) && (e.r[15] != x[15]);
            e.lat = 4'd4;
        end else if (o == 3'd2) begin
            e.r = x - y;
            e.c = (x < y);
            e.v = (x[15] != y[15]) && (e.r[15] != x[15]);
            e.lat = 4'd4;
        end else begin
            e.r = y;
            e.c = 1'b0;
            e.v = 1'b0;
            e.lat = 4'd3;
        end
        e.z = (e.r == 16'd0);
        e.s = e.r[15];
        sb.push_back(e);

        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; a = ~x; b = ~y; op = o ^ 3'd3;
        dones = 0;
        lat   = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (cyc == 1) check("busy_in_lo", busy, 1);
            if (interfere && cyc == 2) begin
                start = 1'b1; op = 3'd2; a = 16'h5555; b = 16'h0001;
            end
            if (interfere && cyc == 3) start = 1'b0;
            @(posedge clk); #1;
            if (done) begin
                dones++;
                if (dones == 1) begin
                    lat = cyc;
                    if (sb.size() == 0) begin
                        check("sb_nonempty", 0, 1);
                    end else begin
                        g = sb.pop_front();
                        check("result",   result,   g.r);
                        check("zero",     zero,     g.z);
                        check("carry",    carry,    g.c);
                        check("sign",     sign,     g.s);
                        check("overflow", overflow, g.v);
                        check("latency",  lat,      g.lat);
                        check("busy_at_done", busy, 0);
                    end
                end
            end
        end
        check("done_count", dones, 1);
        if (dones == 0) void'(sb.pop_front());
    endtask

    initial begin
        int nd;
        rst_n = 1'b0; start = 1'b0; op = 3'd0; a = 16'd0; b = 16'd0;
        #1;
        check("rst_busy",   busy,   0);
        check("rst_done",   done,   0);
        check("rst_result", result, 0);
        check("rst_flags",  {zero, carry, sign, overflow}, 0);
        check("rst_alu",    {alu_a, alu_b, alu_op}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(3'd1, 16'h00FF, 16'h0001, 1'b0);
        run_op(3'd1, 16'hFFFF, 16'h0001, 1'b0);
        run_op(3'd1, 16'h7FFF, 16'h0001, 1'b0);
        run_op(3'd2, 16'h0000, 16'h0001, 1'b0);
        run_op(3'd2, 16'h8000, 16'h0001, 1'b0);
        run_op(3'd0, 16'h0000, 16'h1234, 1'b0);
        run_op(3'd5, 16'hABCD, 16'h80F0, 1'b0);
        run_op(3'd7, 16'h1111, 16'h0000, 1'b0);
        run_op(3'd2, 16'h1234, 16'h1234, 1'b0);
        run_op(3'd1, 16'h00FF, 16'h0001, 1'b1);

        // Abort an ADD while it is in HI
        @(negedge clk);
        start = 1'b1; op = 3'd1; a = 16'h0102; b = 16'h0304;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy",   busy,   0);
        check("abort_done",   done,   0);
        check("abort_result", result, 0);
        check("abort_alu",    {alu_a, alu_b, alu_op}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        check("abort_no_done", nd, 0);
        check("abort_result_after", result, 0);
        check("abort_idle", busy, 0);

        run_op(3'd1, 16'h0001, 16'h0002, 1'b0);

        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_seq16.md
ALU_SEQ16 -- requirements
Module: alu_seq16

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: start  in  1  request; sampled only in IDLE.
REQ-004 SHALL have: op  in  3  0=PASS, 1=ADD, 2=SUB; 3-7 treated as PASS-class (see REQ-019).
REQ-005 SHALL have: a, b  in  16 each  operands, sampled with start.
REQ-006 SHALL have: busy  out  1  high whenever state != IDLE.
REQ-007 SHALL have: done  out  1  one-cycle completion pulse.
REQ-008 SHALL have: result  out  16; zero, carry, sign, overflow  out  1 each; all registered, held until next done.
REQ-009 SHALL have: alu_a, alu_b  out  8 each; alu_op  out  3  drive the external 8-bit ALU.
REQ-010 SHALL have: alu_result  in  8; alu_carry  in  1  combinational ALU response, same cycle.
REQ-011 SHALL treat alu_carry as carry-out on ADD and borrow (1 when alu_a < alu_b unsigned) on SUB.

Function
REQ-012 SHALL implement states IDLE, LO, HI, FIX, DONE; one cycle each except IDLE.
REQ-013 SHALL, in IDLE with start=1 at edge N, latch a, b, op and enter LO at N; start with busy=1 SHALL be ignored, no queuing.
REQ-014 SHALL drive in LO: alu_a=a[7:0], alu_b=b[7:0], alu_op=op; capture result_lo=alu_result, c1=alu_carry.
REQ-015 SHALL drive in HI: alu_a=a[15:8], alu_b=b[15:8], alu_op=op; capture tmp_hi, c2.
REQ-016 SHALL, for ADD/SUB, enter FIX after HI: alu_a=tmp_hi, alu_b={7'b0,c1}, alu_op=op; capture result_hi, c3; final carry=c2|c3.
REQ-017 SHALL, in DONE, update result/flags and assert done for exactly one cycle, then return to IDLE; start is ignored in DONE.
REQ-018 SHALL drive alu_a=0, alu_b=0, alu_op=0 in IDLE and DONE.
REQ-019 SHALL, for PASS-class ops, skip FIX (HI -> DONE): result={tmp_hi,result_lo}, carry=0, overflow=0.
REQ-020 Latency: done high in cycle after edge N+4 for ADD/SUB, N+3 for PASS-class; next start accepted in the cycle after done.
REQ-021 SHALL compute zero=(result==0), sign=result[15].
REQ-022 Overflow SHALL be: ADD a15==b15 and r15!=a15; SUB a15!=b15 and r15!=a15; else 0.
REQ-023 SHALL use latched copies of a, b, op; input changes while busy SHALL NOT affect the operation.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, busy=0, done=0, result=0, all flags 0, alu_* = 0.
REQ-025 Reset mid-operation SHALL abort with no done pulse; outputs read 0 after release.
REQ-026 First start SHALL be honoured at the first rising edge with rst_n high.

Verification (bench drives alu_* through the team 8-bit ALU)
REQ-027 ADD 0x00FF+0x0001 -> result 0x0100, carry0 zero0 sign0 ov0, done at N+4.
REQ-028 ADD 0xFFFF+0x0001 -> 0x0000 zero1 carry1 ov0; ADD 0x7FFF+0x0001 -> 0x8000 sign1 ov1 carry0.
REQ-029 SUB 0x0000-0x0001 -> 0xFFFF carry1 sign1 ov0; SUB 0x8000-0x0001 -> 0x7FFF ov1 carry0.
REQ-030 PASS b=0x1234 -> 0x1234, carry0 ov0, done at N+3; op=5 -> handled as PASS-class, carry0 ov0, done at N+3.
REQ-031 start pulsed in HI with new operands -> ignored; first op completes unchanged; exactly one done.
REQ-032 rst_n low during HI -> busy drops immediately, no done, result 0; subsequent ADD 1+2 -> 0x0003.
